// File: rtl/ps2_emit_if.sv
// ============================================================================
// ps2_emit_if: byte handshake and PS/2 line bundle for ps2_emit (PS2_EMIT_INHIBIT_EN adds inhibit/aborted)
// Revision 1.0
// ============================================================================
`default_nettype none

interface ps2_emit_if;
  logic [7:0] word;
  logic       valid;
  logic       ready;
  logic       clk;
  logic       dat;
  logic       busy;
  logic       done;
`ifdef PS2_EMIT_INHIBIT_EN
  logic       inhibit;
  logic       aborted;

  modport master (
    output word, valid, inhibit,
    input  ready, clk, dat, busy, done, aborted
  );
  modport slave (
    input  word, valid, inhibit,
    output ready, clk, dat, busy, done, aborted
  );
`else
  modport master (
    output word, valid,
    input  ready, clk, dat, busy, done
  );
  modport slave (
    input  word, valid,
    output ready, clk, dat, busy, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/ps2_emit.sv
// ============================================================================
// ps2_emit: device-side PS/2 transmitter, start/8 data LSB-first/odd parity/stop.
// Optional host-inhibit abort path: PS2_EMIT_INHIBIT_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module ps2_emit #(
  parameter int HALF_PERIOD = 4,
  parameter int IDLE_GAP    = 8
) (
  input  wire logic   sysclk,
  input  wire logic   rst_n,
  ps2_emit_if.slave   bus
);

  localparam int CNT_MAX = (HALF_PERIOD > IDLE_GAP) ? HALF_PERIOD : IDLE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      idx, idx_n;
  logic [7:0]      word_q, word_n;
  logic            parity_q, parity_n;
  logic            clk_q, clk_n;
  logic            dat_q, dat_n;
  logic            ready_q, ready_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic [10:0]     frame;
  logic            half_end;
  logic            gap_end;
`ifdef PS2_EMIT_INHIBIT_EN
  logic            aborted_q, aborted_n;
  logic            restart_q, restart_n;
`endif

  assign frame    = {1'b1, parity_q, word_q, 1'b0};
  assign half_end = (cnt == HP_LAST);
  assign gap_end  = (cnt == GAP_LAST);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 4'd0;
      word_q    <= 8'd0;
      parity_q  <= 1'b0;
      clk_q     <= 1'b1;
      dat_q     <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PS2_EMIT_INHIBIT_EN
      aborted_q <= 1'b0;
      restart_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      word_q    <= word_n;
      parity_q  <= parity_n;
      clk_q     <= clk_n;
      dat_q     <= dat_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
`ifdef PS2_EMIT_INHIBIT_EN
      aborted_q <= aborted_n;
      restart_q <= restart_n;
`endif
    end
  end

  // Line values are computed for the next state so clk/dat come straight from flops.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    word_n    = word_q;
    parity_n  = parity_q;
    clk_n     = clk_q;
    dat_n     = dat_q;
    done_n    = 1'b0;
`ifdef PS2_EMIT_INHIBIT_EN
    aborted_n = 1'b0;
    restart_n = restart_q;
`endif
    case (state)
      S_IDLE: begin
        clk_n = 1'b1;
        dat_n = 1'b1;
        if (bus.valid && ready_q) begin
          word_n   = bus.word;
          parity_n = ~^bus.word;
          idx_n    = 4'd0;
          cnt_n    = '0;
          state_n  = S_HIGH;
          dat_n    = 1'b0;
        end
      end
      S_HIGH: begin
`ifdef PS2_EMIT_INHIBIT_EN
        if (bus.inhibit && (idx <= 4'd9)) begin
          state_n   = S_GAP;
          cnt_n     = '0;
          idx_n     = 4'd0;
          clk_n     = 1'b1;
          dat_n     = 1'b1;
          aborted_n = 1'b1;
          restart_n = 1'b1;
        end else
`endif
        if (half_end) begin
          state_n = S_LOW;
          cnt_n   = '0;
          clk_n   = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LOW: begin
        if (half_end) begin
          cnt_n = '0;
          clk_n = 1'b1;
          if (idx == 4'd10) begin
            state_n = S_GAP;
            dat_n   = 1'b1;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = S_HIGH;
            dat_n   = frame[idx_n];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        clk_n = 1'b1;
        dat_n = 1'b1;
        if (gap_end) begin
`ifdef PS2_EMIT_INHIBIT_EN
          // An aborted frame waits here until the host releases the line.
          if (restart_q) begin
            if (!bus.inhibit) begin
              restart_n = 1'b0;
              state_n   = S_HIGH;
              cnt_n     = '0;
              idx_n     = 4'd0;
              dat_n     = 1'b0;
            end
          end else begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end
`else
          state_n = S_IDLE;
          cnt_n   = '0;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        clk_n   = 1'b1;
        dat_n   = 1'b1;
      end
    endcase

`ifdef PS2_EMIT_INHIBIT_EN
    ready_n = (state_n == S_IDLE) && !bus.inhibit;
`else
    ready_n = (state_n == S_IDLE);
`endif
    busy_n = (state_n != S_IDLE);
  end

  assign bus.ready   = ready_q;
  assign bus.clk     = clk_q;
  assign bus.dat     = dat_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
`ifdef PS2_EMIT_INHIBIT_EN
  assign bus.aborted = aborted_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_emit.sv
// ============================================================================
// tb_ps2_emit: scoreboard bench; a monitor deserialises PS/2 frames and checks them.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ps2_emit;

  localparam int H   = 4;
  localparam int G   = 8;
  localparam int TMO = 400;

  typedef struct {
    logic [7:0] w;
    logic       p;
    longint     acc;
    bit         lat;
  } exp_t;

  logic   sysclk = 1'b0;
  logic   rst_n  = 1'b0;
  longint cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  int     n_push = 0;
  int     done_cnt = 0;
  int     viol   = 0;
  longint last_acc = 0;
  exp_t   q[$];

  ps2_emit_if ifc ();

  ps2_emit #(.HALF_PERIOD(H), .IDLE_GAP(G)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (ifc)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples lines on negedge, collects bits on each clk fall, checks on done.
  logic       prev_clk = 1'b1;
  int         nbits = 0;
  logic [10:0] bits;
  longint     fall_cyc = 0;

  always @(negedge sysclk) begin
    if (!rst_n) begin
      nbits    = 0;
      prev_clk = 1'b1;
    end else begin
      if (ifc.busy && ifc.ready) viol++;
`ifdef PS2_EMIT_INHIBIT_EN
      if (ifc.aborted) nbits = 0;
`endif
      if (prev_clk && !ifc.clk) begin
        if (nbits == 0 && q.size() > 0 && q[0].lat)
          chk("first_fall_latency", cyc - q[0].acc, H);
        if (nbits < 11) bits[nbits] = ifc.dat;
        nbits++;
        fall_cyc = cyc;
      end
      if (ifc.done) begin
        exp_t e;
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("bit_count", nbits, 11);
          chk("start_bit", bits[0], 0);
          chk("data_byte", bits[8:1], e.w);
          chk("parity_bit", bits[9], e.p);
          chk("stop_bit", bits[10], 1);
          chk("done_after_stop_fall", cyc - fall_cyc, H);
          if (e.lat) chk("accept_to_done", cyc - e.acc, 22 * H);
        end
        nbits = 0;
      end
      prev_clk = ifc.clk;
    end
  end

  task automatic send(input logic [7:0] w, input bit keep, input logic p,
                      input bit push, input bit lat);
    int n;
    @(negedge sysclk);
    ifc.word  = w;
    ifc.valid = 1'b1;
    n = 0;
    while (!ifc.ready && n < TMO) begin
      @(negedge sysclk);
      n++;
    end
    if (!ifc.ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", w, TMO);
      ifc.valid = 1'b0;
    end else begin
      last_acc = cyc + 1;
      if (push) begin
        q.push_back('{w: w, p: p, acc: last_acc, lat: lat});
        n_push++;
      end
      @(posedge sysclk);
      #1;
      if (!keep) ifc.valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ifc.busy) && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    if (q.size() != 0 || ifc.busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d frames pending, busy %0d", q.size(), ifc.busy);
    end
  endtask

  task automatic wait_cyc(input longint c);
    int n;
    n = 0;
    while (cyc < c && n < TMO) begin
      @(negedge sysclk);
      n++;
    end
  endtask

  initial begin
    longint a1;
    ifc.word  = 8'h00;
    ifc.valid = 1'b0;
`ifdef PS2_EMIT_INHIBIT_EN
    ifc.inhibit = 1'b0;
`endif
    repeat (3) @(negedge sysclk);
    chk("reset_clk", ifc.clk, 1);
    chk("reset_dat", ifc.dat, 1);
    chk("reset_ready", ifc.ready, 1);
    chk("reset_busy", ifc.busy, 0);
    chk("reset_done", ifc.done, 0);
    rst_n = 1'b1;

    // single frame 0x1C: bits 0,0,0,1,1,1,0,0,0,par 0,stop 1
    send(8'h1C, 0, 1'b0, 1, 1);
    drain();

    // back-to-back with valid held high
    send(8'h00, 1, 1'b1, 1, 1);
    a1 = last_acc;
    send(8'hFF, 0, 1'b1, 1, 1);
    chk("accept_to_accept", last_acc - a1, 22 * H + G + 1);
    drain();

    send(8'hA5, 1, 1'b1, 1, 1);
    send(8'h5A, 1, 1'b1, 1, 1);
    send(8'h01, 0, 1'b0, 1, 1);
    drain();

    // reset mid-frame at index 5; abandoned word is never expected
    send(8'h77, 0, 1'b0, 0, 0);
    wait_cyc(last_acc + 10 * H + 1);
    rst_n = 1'b0;
    @(negedge sysclk);
    chk("midreset_clk", ifc.clk, 1);
    chk("midreset_dat", ifc.dat, 1);
    chk("midreset_ready", ifc.ready, 1);
    chk("midreset_busy", ifc.busy, 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    send(8'h3C, 0, 1'b1, 1, 1);
    drain();

    // second word presented mid-frame is only taken after the gap
    send(8'h81, 0, 1'b1, 1, 1);
    a1 = last_acc;
    repeat (20) @(negedge sysclk);
    send(8'h7E, 0, 1'b1, 1, 1);
    chk("midframe_accept_delay", last_acc - a1, 22 * H + G + 1);
    drain();

`ifdef PS2_EMIT_INHIBIT_EN
    begin
      int n;
      send(8'h5B, 0, 1'b0, 1, 0);
      wait_cyc(last_acc + 6 * H + 1);
      ifc.inhibit = 1'b1;
      n = 0;
      @(negedge sysclk);
      while (!ifc.aborted && n < 5) begin
        @(negedge sysclk);
        n++;
      end
      chk("aborted_pulse", ifc.aborted, 1);
      chk("abort_clk", ifc.clk, 1);
      chk("abort_dat", ifc.dat, 1);
      repeat (30) @(negedge sysclk);
      chk("inhibit_hold_busy", ifc.busy, 1);
      ifc.inhibit = 1'b0;
      drain();
    end
`endif

    repeat (5) @(negedge sysclk);
    chk("done_pulse_count", done_cnt, n_push);
    chk("ready_while_busy", viol, 0);
    chk("final_idle_ready", ifc.ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
